// File: rtl/pmem_acc_reader.sv
// Read-side accumulation engine for PMEM: walks every kernel offset of each
// output pixel, sums the partial-sum vectors per lane and streams the result.
module pmem_acc_reader #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int len_kij  = 9,
    parameter int len_onij = 16,
    parameter int addr_bw  = 11,
    parameter bit relu_en  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     CEN_pmem,
    output logic                     WEN_pmem,
    output logic [addr_bw-1:0]       A_pmem,
    input  logic [col*psum_bw-1:0]   Q_pmem,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   out_data,
    output logic [3:0]               out_idx,
    output logic [2:0]               state_dbg
);

    localparam int KW = (len_kij > 1) ? $clog2(len_kij) : 1;
    localparam int OW = (len_onij > 1) ? $clog2(len_onij) : 1;
    localparam logic [KW-1:0] KIJ_LAST  = KW'(len_kij - 1);
    localparam logic [OW-1:0] ONIJ_LAST = OW'(len_onij - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] OUT   = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]             state;
    logic [addr_bw-1:0]     base_q;
    logic [KW-1:0]          kij;
    logic [OW-1:0]          onij;
    logic [col*psum_bw-1:0] acc;
    logic                   rd_pend;
    logic                   rd_first;
    logic [addr_bw-1:0]     rd_addr;

    // Address arithmetic is done at addr_bw width so it wraps naturally.
    assign rd_addr = base_q
                   + (addr_bw'(kij) * addr_bw'(len_onij))
                   + addr_bw'(onij);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            kij      <= '0;
            onij     <= '0;
            acc      <= '0;
            rd_pend  <= 1'b0;
            rd_first <= 1'b0;
        end else begin
            // A read issued this cycle returns data on the next one.
            rd_pend  <= (state == RD);
            rd_first <= (state == RD) && (kij == '0);

            if (rd_pend) begin
                for (int c = 0; c < col; c++) begin
                    if (rd_first)
                        acc[c*psum_bw +: psum_bw] <= Q_pmem[c*psum_bw +: psum_bw];
                    else
                        acc[c*psum_bw +: psum_bw] <= acc[c*psum_bw +: psum_bw]
                                                   + Q_pmem[c*psum_bw +: psum_bw];
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        onij   <= '0;
                        kij    <= '0;
                        state  <= RD;
                    end
                end
                RD: begin
                    if (kij == KIJ_LAST) begin
                        kij   <= '0;
                        state <= DRAIN;
                    end else begin
                        kij <= kij + KW'(1);
                    end
                end
                DRAIN: state <= OUT;
                OUT: begin
                    if (out_ready) begin
                        if (onij == ONIJ_LAST) begin
                            state <= FIN;
                        end else begin
                            onij  <= onij + OW'(1);
                            kij   <= '0;
                            state <= RD;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output handshake: out_valid is held with out_data/out_idx stable until a
    // rising edge sees out_valid && out_ready; only then does the pass advance.
    assign out_valid = (state == OUT);
    assign out_idx   = 4'(onij);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign CEN_pmem  = (state != RD);
    assign WEN_pmem  = 1'b1;
    assign A_pmem    = (state == RD) ? rd_addr : '0;
    assign state_dbg = state;

    always_comb begin
        out_data = '0;
        for (int c = 0; c < col; c++) begin
            if (relu_en && acc[c*psum_bw + psum_bw - 1])
                out_data[c*psum_bw +: psum_bw] = '0;
            else
                out_data[c*psum_bw +: psum_bw] = acc[c*psum_bw +: psum_bw];
        end
    end

endmodule

// File: tb/tb_pmem_acc_reader.sv
// Directed bench for pmem_acc_reader: two instances (ReLU on / off) share the
// stimulus and a behavioural PMEM, and a scoreboard checks every output.
module tb_pmem_acc_reader;

    localparam int W = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [10:0]   base_addr;
    logic          out_ready;

    logic          busy_a, done_a, cen_a, wen_a, valid_a;
    logic [10:0]   a_a;
    logic [W-1:0]  q_a, data_a;
    logic [3:0]    idx_a;
    logic [2:0]    st_a;

    logic          busy_b, done_b, cen_b, wen_b, valid_b;
    logic [10:0]   a_b;
    logic [W-1:0]  q_b, data_b;
    logic [3:0]    idx_b;
    logic [2:0]    st_b;

    logic [W-1:0]  mem [0:2047];
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_raw_q[$];
    logic [10:0]   addr_log[$];

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pmem_acc_reader #(.relu_en(1'b1)) u_dut_relu (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy_a), .done(done_a), .CEN_pmem(cen_a), .WEN_pmem(wen_a),
        .A_pmem(a_a), .Q_pmem(q_a), .out_valid(valid_a), .out_ready(out_ready),
        .out_data(data_a), .out_idx(idx_a), .state_dbg(st_a)
    );

    pmem_acc_reader #(.relu_en(1'b0)) u_dut_raw (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy_b), .done(done_b), .CEN_pmem(cen_b), .WEN_pmem(wen_b),
        .A_pmem(a_b), .Q_pmem(q_b), .out_valid(valid_b), .out_ready(out_ready),
        .out_data(data_b), .out_idx(idx_b), .state_dbg(st_b)
    );

    always @(posedge clk) begin
        if (!cen_a) q_a <= mem[a_a];
        if (!cen_b) q_b <= mem[a_b];
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- memory fill ----------------
    task automatic fill_zero();
        for (int i = 0; i < 2048; i++) mem[i] = '0;
    endtask

    task automatic fill_kij();
        for (int k = 0; k < 9; k++)
            for (int o = 0; o < 16; o++)
                mem[k*16 + o] = {8{16'(k + 1)}};
    endtask

    task automatic fill_mixed();
        for (int i = 0; i < 144; i++)
            mem[i] = 128'h0000_0000_0000_0000_0001_7000_000A_FFF6;
    endtask

    // ---------------- driver + scoreboard for one tile ----------------
    task automatic run_tile(input string tag, input logic [10:0] base, input int stall_k,
                            input int restart_rel, input logic [W-1:0] exp_relu,
                            input logic [W-1:0] exp_raw);
        int rel;
        int first_valid;
        int done_rel;
        int n_done;
        int n_out;
        int post;
        int done_exp;
        int hs_rel[$];
        logic [10:0] ea;

        done_exp = 177 + ((stall_k >= 0) ? 5 : 0);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(exp_relu);
            exp_raw_q.push_back(exp_raw);
        end
        addr_log.delete();
        first_valid = -1;
        done_rel = -1;
        n_done = 0;
        n_out = 0;
        post = 0;

        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        out_ready = 1'b1;
        rel = 0;

        while (rel < 400 && post < 2) begin
            @(posedge clk); #1;
            rel++;
            start = (rel == restart_rel) || (rel == done_exp);
            base_addr = (rel == restart_rel) ? 11'h200 : base;
            out_ready = !(stall_k >= 0 && rel >= 11 + 11*stall_k && rel <= 15 + 11*stall_k);
            @(negedge clk);
            if (!cen_a) addr_log.push_back(a_a);
            if (valid_a && first_valid < 0) first_valid = rel;

            if (stall_k >= 0 && rel >= 11 + 11*stall_k && rel <= 15 + 11*stall_k) begin
                check($sformatf("%s_stall_valid_r%0d", tag, rel), W'(valid_a), W'(1));
                check($sformatf("%s_stall_idx_r%0d", tag, rel), W'(idx_a), W'(stall_k));
                check($sformatf("%s_stall_data_r%0d", tag, rel), data_a, exp_relu);
                check($sformatf("%s_stall_cen_r%0d", tag, rel), W'(cen_a), W'(1));
            end
            if (stall_k >= 0 && rel == 16 + 11*stall_k)
                check({tag, "_hs_cycle_cen"}, W'(cen_a), W'(1));
            if (stall_k >= 0 && rel == 17 + 11*stall_k) begin
                check({tag, "_resume_cen"}, W'(cen_a), W'(0));
                ea = base + 11'(stall_k + 1);
                check({tag, "_resume_addr"}, W'(a_a), W'(ea));
            end

            if (valid_a && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected_out"}, W'(1), W'(0));
                end else begin
                    check($sformatf("%s_data_relu_%0d", tag, n_out), data_a, exp_q.pop_front());
                    check($sformatf("%s_data_raw_%0d", tag, n_out), data_b, exp_raw_q.pop_front());
                    check($sformatf("%s_idx_%0d", tag, n_out), W'(idx_a), W'(n_out));
                end
                hs_rel.push_back(rel);
                n_out++;
            end

            if (done_a) begin
                n_done++;
                done_rel = rel;
            end else if (done_rel >= 0) begin
                check($sformatf("%s_busy_after_fin_%0d", tag, post), W'(busy_a), W'(0));
                post++;
            end
        end

        check({tag, "_timeout"}, W'(done_rel >= 0), W'(1));
        check({tag, "_first_valid"}, W'(first_valid), W'(11));
        check({tag, "_done_cycle"}, W'(done_rel), W'(done_exp));
        check({tag, "_done_count"}, W'(n_done), W'(1));
        check({tag, "_out_count"}, W'(n_out), W'(16));
        check({tag, "_read_count"}, W'(addr_log.size()), W'(144));
        check({tag, "_wen"}, W'(wen_a), W'(1));
        if (addr_log.size() >= 36) begin
            for (int k = 0; k < 9; k++) begin
                ea = base + 11'(16*k + 3);
                check($sformatf("%s_addr_o3_k%0d", tag, k), W'(addr_log[27 + k]), W'(ea));
            end
        end
        if (hs_rel.size() >= 6)
            check({tag, "_o5_minus_o4"}, W'(hs_rel[5] - hs_rel[4]), W'(11));
        check({tag, "_sb_empty"}, W'(exp_q.size()), W'(0));
        exp_q.delete();
        exp_raw_q.delete();
    endtask

    // ---------------- reset in the middle of a pass ----------------
    task automatic run_reset_mid();
        int rel;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 11'h000;
        out_ready = 1'b1;
        rel = 0;
        while (rel < 82) begin
            @(posedge clk); #1;
            rel++;
            start = 1'b0;
            if (rel == 82) begin
                reset = 1'b1;
                start = 1'b1;
            end
            @(negedge clk);
        end
        check("rmid_pre_cen", W'(cen_a), W'(0));
        check("rmid_pre_addr", W'(a_a), W'(11'd71));
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rmid_cen", W'(cen_a), W'(1));
        check("rmid_busy", W'(busy_a), W'(0));
        check("rmid_valid", W'(valid_a), W'(0));
        check("rmid_done", W'(done_a), W'(0));
        check("rmid_addr", W'(a_a), W'(0));
        check("rmid_data", data_a, '0);
        check("rmid_idx", W'(idx_a), W'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("rmid_no_start", W'(busy_a), W'(0));
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        fill_zero();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", W'(busy_a), W'(0));
        check("rst_done", W'(done_a), W'(0));
        check("rst_cen", W'(cen_a), W'(1));
        check("rst_wen", W'(wen_a), W'(1));
        check("rst_addr", W'(a_a), W'(0));
        check("rst_valid", W'(valid_a), W'(0));
        check("rst_data", data_a, '0);
        check("rst_idx", W'(idx_a), W'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        run_tile("zero", 11'h000, -1, -1, '0, '0);

        fill_kij();
        run_tile("kij", 11'h000, -1, -1, {8{16'h002D}}, {8{16'h002D}});

        fill_mixed();
        run_tile("mixed", 11'h000, 2, -1,
                 128'h0000_0000_0000_0000_0009_0000_005A_0000,
                 128'h0000_0000_0000_0000_0009_F000_005A_FFA6);

        run_reset_mid();

        fill_zero();
        run_tile("restart", 11'h100, -1, 5, '0, '0);
        if (addr_log.size() >= 3) begin
            check("restart_addr0", W'(addr_log[0]), W'(11'h100));
            check("restart_addr1", W'(addr_log[1]), W'(11'h110));
            check("restart_addr2", W'(addr_log[2]), W'(11'h120));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
